// File: rtl/tug_pkg.sv
// Shared types and defaults for the tug-of-war key front end.
package tug_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } deb_state_e;

   localparam int DEB_CYCLES_DEF = 500000;

endpackage

// File: rtl/tug_key_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM with counter,
// registered press pulse (one cycle after the press transition) and held level.
//
// state      | meaning
// IDLE       | debounced released, waiting for a pressed sample
// PRESS_DB   | pressed samples seen, counting towards acceptance
// HELD       | debounced pressed, waiting for a released sample
// RELEASE_DB | released samples seen, counting towards release
module tug_key_chan
   import tug_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n_i,
   output logic press_o,
   output logic held_o
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

   logic             sync1_q;
   logic             sync2_q;
   deb_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             press_q;
   logic             held_q;
   logic             p;

   assign p = ~sync2_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         press_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         sync1_q <= key_n_i;
         sync2_q <= sync1_q;
         press_q <= 1'b0;
         // held follows the state one cycle late so it rises with the pulse
         held_q  <= (state_q == HELD) || (state_q == RELEASE_DB);
         case (state_q)
            IDLE: begin
               if (p) begin
                  state_q <= PRESS_DB;
                  cnt_q   <= CNT_W'(1);
               end
            end
            PRESS_DB: begin
               if (!p) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q <= HELD;
                  cnt_q   <= '0;
                  press_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            HELD: begin
               if (!p) begin
                  state_q <= RELEASE_DB;
                  cnt_q   <= CNT_W'(1);
               end
            end
            RELEASE_DB: begin
               if (p) begin
                  state_q <= HELD;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign press_o = press_q;
   assign held_o  = held_q;

endmodule

// File: rtl/tug_key_ctrl.sv
// Player-input front end: two debounced key channels producing one-cycle
// L/R press pulses, masked while the game is frozen.
module tug_key_ctrl
   import tug_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_l_n,
   input  logic key_r_n,
   input  logic freeze,
   output logic L,
   output logic R,
   output logic held_l,
   output logic held_r
);

   logic press_l;
   logic press_r;
   logic l_q;
   logic r_q;

   tug_key_chan #(.DEB_CYCLES(DEB_CYCLES)) u_chan_l (
      .clk     (clk),
      .reset_n (reset_n),
      .key_n_i (key_l_n),
      .press_o (press_l),
      .held_o  (held_l)
   );

   tug_key_chan #(.DEB_CYCLES(DEB_CYCLES)) u_chan_r (
      .clk     (clk),
      .reset_n (reset_n),
      .key_n_i (key_r_n),
      .press_o (press_r),
      .held_o  (held_r)
   );

   // A masked pulse is dropped, not deferred; the channel has already moved to HELD.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         l_q <= 1'b0;
         r_q <= 1'b0;
      end else begin
         l_q <= press_l & ~freeze;
         r_q <= press_r & ~freeze;
      end
   end

   assign L = l_q;
   assign R = r_q;

endmodule

// File: doc/tug_key_ctrl.md
Name: tug_key_ctrl

Overview:
Player-input front end for the tug-of-war game. It turns the two raw, active-low, bouncing push-buttons into the clean one-cycle L and R press pulses that the playfield light cells consume. Each key gets synchronisation, debounce and press-edge detection. The block also suppresses pulses while the game is frozen.

Parameters:
DEB_CYCLES, 500000, number of consecutive stable cycles needed to accept a key level change (≥1; benches use 4)
CNT_W, $clog2(DEB_CYCLES+1), debounce counter width (derived; not overridden)

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
key_l_n  input  1  raw left key (KEY[3]), 0 = pressed, asynchronous to clk
key_r_n  input  1  raw right key (KEY[0]), 0 = pressed, asynchronous to clk
freeze  input  1  1 = game over or paused; press pulses are masked
L  output  1  one-cycle pulse for an accepted left press
R  output  1  one-cycle pulse for an accepted right press
held_l  output  1  debounced left key level (1 = held)
held_r  output  1  debounced right key level (1 = held)

Behaviour:
- Reset: one clock, asynchronous and active-low. While reset_n=0, all flops clear immediately.
  - L=R=0, held_l=held_r=0.
  - Both channel FSMs go to IDLE, counters to 0.
  - Synchroniser flops reset to "released", value 1.
- Reset deassertion is not synchronised inside this block; the top level supplies a synchronised release.
- Per channel (identical, independent):
  - 2-flop synchroniser on the raw key. Internal sample p = ~sync2, so 1 means pressed.
- Channel FSM states:
  - IDLE: debounced released. If p=1, go to PRESS_DB with cnt=1; else stay.
  - PRESS_DB: if p=0, go to IDLE with cnt=0 (bounce rejected). Else if cnt==DEB_CYCLES, go to HELD and fire the press event. Else cnt++.
  - HELD: debounced pressed. If p=0, go to RELEASE_DB with cnt=1.
  - RELEASE_DB: if p=1, return to HELD with cnt=0. Else if cnt==DEB_CYCLES, go to IDLE. Else cnt++.
- held_x = 1 in HELD and RELEASE_DB; 0 in IDLE and PRESS_DB. held_x is registered.
- Press event and outputs:
  - The press event is the PRESS_DB→HELD transition.
  - L/R are registered and are high for exactly the one cycle after that transition.
  - L/R are low in every other cycle.
- Latency: raw key goes low and stays low from edge N. The pulse is high in the cycle beginning at edge N+2+DEB_CYCLES+1. Total latency = DEB_CYCLES+3 edges.
- Holding a key produces exactly one pulse. No auto-repeat. A new pulse needs a debounced release followed by a debounced press.
- Bounce shorter than DEB_CYCLES samples never produces a pulse and never changes held_x.
- Simultaneous presses: if both channels fire in the same cycle, L=R=1 together. Resolution belongs to the light cells, which treat L&R as no movement.
- freeze:
  - When freeze=1 in the cycle a press event occurs, that pulse is dropped.
  - The FSM still enters HELD, so releasing freeze while a key is held does not fire a pulse.
  - freeze never alters the FSMs or held_x.
- Counter saturates logically at DEB_CYCLES. It never wraps, because the state always exits on the ==DEB_CYCLES check.
- reset_n asserted mid-debounce or mid-hold: the channel returns to IDLE at once. A key still held after reset must pass a full debounce and then produces one pulse.

Decomposition:
- Package tug_pkg holds the debounce state enum (IDLE, PRESS_DB, HELD, RELEASE_DB) and the default DEB_CYCLES constant.
- One sub-module, tug_key_chan: synchroniser + FSM + counter + registered pulse and held outputs. It is instantiated twice.
- The top applies freeze masking to both channel pulses.

Test Plan:
- Reset (DEB_CYCLES=4): hold reset_n=0 mid-cycle, check outputs clear without a clock edge. After release with keys high, L=R=held_l=held_r=0 for 20 cycles.
- Clean left press: key_l_n low at edge 10, held. L=1 only in the cycle after edge 17, never again. held_l rises with it. R stays 0.
- Bounce rejection: key_r_n toggles low 3 cycles, high 1 cycle, repeated 5 times → R never pulses, held_r stays 0. Then low for 10 cycles → exactly one R pulse.
- Simultaneous: both keys low at the same edge → L and R both high in the same single cycle. After release and re-press of only the left key → only L pulses.
- Freeze: freeze=1 during a left press → no L pulse but held_l=1. Drop freeze while still held → no pulse. Release, then re-press → one L pulse.
- Reset mid-hold: left key held (held_l=1), pulse reset_n low for 1 cycle, keep key pressed → held_l clears. Exactly one L pulse arrives DEB_CYCLES+3 edges after reset release.
